omsp_spm_key_loader: RTL and testbench
======================================

OMSP_SPM_KEY_LOADER -- requirements
Module: omsp_spm_key_loader

Interface
REQ-001 SHALL have parameter KEY_IDX_SIZE, default 3, giving the width of key_idx.
REQ-002 SHALL have parameter KEY_WORDS, default 8, giving the number of 16-bit key words per load (`SECURITY/16).
REQ-003 SHALL have port mclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port puc_rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-005 SHALL have port start, input, 1 bit: request to load a key into the SM containing sm_addr.
REQ-006 SHALL have port sm_addr, input, 16 bits: address inside the target SM public section.
REQ-007 SHALL have port abort, input, 1 bit: cancel the current load.
REQ-008 SHALL have port word_valid, input, 1 bit: the key source offers word_data.
REQ-009 SHALL have port word_data, input, 16 bits: key word; the first word accepted goes to index 0.
REQ-010 SHALL have port word_ready, output, 1 bit: the loader accepts word_data this cycle.
REQ-011 SHALL have port key_selected, input, 1 bit: OR of all SM key_selected outputs.
REQ-012 SHALL have port spm_key_select, output, 16 bits: address broadcast to the SMs.
REQ-013 SHALL have port write_key, output, 1 bit: key write strobe to the SMs.
REQ-014 SHALL have port key_in, output, 16 bits: key word being written.
REQ-015 SHALL have port key_idx, output, KEY_IDX_SIZE bits: 16-bit word index of the write.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse when a load completes.
REQ-018 SHALL have port error, output, 1 bit: one-cycle pulse when a load fails or is aborted.

Function
REQ-019 SHALL implement the states IDLE, CHECK, LOAD, DONE and ERR, plus WIPE when SM_KEY_WIPE_EN is defined.
REQ-020 In IDLE, start SHALL latch sm_addr into spm_key_select and go to CHECK; in all other states start SHALL be ignored.
REQ-021 In CHECK (one cycle), key_selected=1 SHALL clear the word counter and go to LOAD; key_selected=0 SHALL go to ERR.
REQ-022 word_ready SHALL equal (state==LOAD) & key_selected & ~abort, combinationally.
REQ-023 A word SHALL be accepted when word_valid & word_ready.
REQ-024 An accepted word SHALL produce, in the next cycle only, write_key=1, key_in=word_data and key_idx=counter; the counter SHALL then increment.
REQ-025 Acceptance of word KEY_WORDS-1 SHALL go to DONE; DONE SHALL last one cycle with done=1 and then go to IDLE.
REQ-026 spm_key_select SHALL hold its latched value from CHECK through the cycle of the final write_key.
REQ-027 spm_key_select SHALL return to 0 on entry to IDLE.
REQ-028 If key_selected=0 in any LOAD cycle, the loader SHALL go to ERR (or WIPE if enabled) and accept no further words.
REQ-029 abort in CHECK, LOAD or DONE SHALL win over a same-cycle handshake and go to ERR (or WIPE if enabled).
REQ-030 A write already registered before the abort SHALL still appear.
REQ-031 An abort in DONE SHALL suppress done.
REQ-032 ERR SHALL last one cycle with error=1 and then go to IDLE.
REQ-033 write_key SHALL be 0 in every cycle not specified by REQ-024 or REQ-043.
REQ-034 key_in and key_idx SHALL hold their last values while write_key=0.
REQ-035 key_idx SHALL never exceed KEY_WORDS-1; the counter SHALL not wrap within a load.
REQ-036 Word stalls (word_valid=0 in LOAD) SHALL be unbounded with no timeout.

Reset
REQ-037 puc_rst_n=0 SHALL immediately force state IDLE and counter 0.
REQ-038 puc_rst_n=0 SHALL immediately force spm_key_select=0, key_in=0, key_idx=0, write_key=0, done=0, error=0 and busy=0.
REQ-039 word_ready SHALL read 0 during reset.
REQ-040 Reset mid-load SHALL drop any pending write with no further strobes; release SHALL resume in IDLE.

Configuration
REQ-041 The macro SM_KEY_WIPE_EN SHALL select the wipe behaviour.
REQ-042 With SM_KEY_WIPE_EN undefined, the WIPE state SHALL not exist and failures SHALL go directly to ERR.
REQ-043 With SM_KEY_WIPE_EN defined, a failure in LOAD or DONE SHALL enter WIPE, which issues write_key with key_in=0 for key_idx 0..KEY_WORDS-1, one per cycle, while key_selected=1.
REQ-044 WIPE SHALL go to ERR after the last index or when key_selected drops, and SHALL ignore abort.
REQ-045 CHECK failures SHALL never enter WIPE.

Verification
REQ-046 SM at 0x8000-0x9000; start with sm_addr=0x8100; words 0x1111..0x8888 back-to-back -> 8 write_key strobes, idx 0..7, each one cycle after acceptance; done pulses 1 cycle after the 8th write; spm_key_select=0x8100 until then, then 0.
REQ-047 start with sm_addr=0x7000 and key_selected=0 -> error pulses 2 cycles after start; no write_key; word_ready never high.
REQ-048 word_valid toggled 1,0,0,1,... -> key_idx strictly sequential; no duplicate or missed writes.
REQ-049 abort in the same cycle as the 4th handshake -> word 4 not accepted; 3 writes total; error pulse; with SM_KEY_WIPE_EN, 8 zero writes idx 0..7 then error.
REQ-050 key_selected dropped after the 2nd write -> word_ready falls the same cycle; error; no wipe writes.
REQ-051 puc_rst_n asserted mid-load at idx 5 -> all outputs 0 asynchronously; after release a new start completes normally.

Source files
------------

// File: rtl/omsp_spm_key_loader.sv
// Streams KEY_WORDS 16-bit key words into the protected module that owns sm_addr.
// Optional macro SM_KEY_WIPE_EN: a failed or aborted load zeroes the partially written key.
module omsp_spm_key_loader #(
    parameter int unsigned KEY_IDX_SIZE = 3,
    parameter int unsigned KEY_WORDS    = 8
) (
    input  logic                    mclk,
    input  logic                    puc_rst_n,
    input  logic                    start,
    input  logic [15:0]             sm_addr,
    input  logic                    abort,
    input  logic                    word_valid,
    input  logic [15:0]             word_data,
    output logic                    word_ready,
    input  logic                    key_selected,
    output logic [15:0]             spm_key_select,
    output logic                    write_key,
    output logic [15:0]             key_in,
    output logic [KEY_IDX_SIZE-1:0] key_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX = KEY_IDX_SIZE'(KEY_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_LOAD  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
`ifdef SM_KEY_WIPE_EN
        , S_WIPE = 3'd5
`endif
    } state_t;

    // Destination of a failure detected after the target SM has been confirmed.
`ifdef SM_KEY_WIPE_EN
    localparam state_t S_FAIL = S_WIPE;
`else
    localparam state_t S_FAIL = S_ERR;
`endif

    state_t                  r_state;
    logic [KEY_IDX_SIZE-1:0] r_cnt;
    logic [15:0]             r_sel;
    logic                    r_write;
    logic [15:0]             r_key_in;
    logic [KEY_IDX_SIZE-1:0] r_key_idx;
    logic                    r_done;
    logic                    w_accept;

    assign word_ready     = (r_state == S_LOAD) & key_selected & ~abort;
    assign w_accept       = word_valid & word_ready;
    assign spm_key_select = r_sel;
    assign write_key      = r_write;
    assign key_in         = r_key_in;
    assign key_idx        = r_key_idx;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
    assign error          = (r_state == S_ERR);

    // Load sequencer; strobes default low, key_in/key_idx hold between writes.
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sel     <= '0;
            r_write   <= 1'b0;
            r_key_in  <= '0;
            r_key_idx <= '0;
            r_done    <= 1'b0;
        end else begin
            r_write <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sel   <= sm_addr;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (abort || !key_selected) begin
                        r_state <= S_ERR;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort || !key_selected) begin
                        r_cnt   <= '0;
                        r_state <= S_FAIL;
                    end else if (w_accept) begin
                        r_write   <= 1'b1;
                        r_key_in  <= word_data;
                        r_key_idx <= r_cnt;
                        if (r_cnt == LAST_IDX) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + KEY_IDX_SIZE'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (abort) begin
                        r_cnt   <= '0;
                        r_state <= S_FAIL;
                    end else begin
                        r_done  <= 1'b1;
                        r_sel   <= '0;
                        r_state <= S_IDLE;
                    end
                end
`ifdef SM_KEY_WIPE_EN
                S_WIPE: begin
                    if (!key_selected) begin
                        r_state <= S_ERR;
                    end else begin
                        r_write   <= 1'b1;
                        r_key_in  <= '0;
                        r_key_idx <= r_cnt;
                        if (r_cnt == LAST_IDX) begin
                            r_state <= S_ERR;
                        end else begin
                            r_cnt <= r_cnt + KEY_IDX_SIZE'(1);
                        end
                    end
                end
`endif
                S_ERR: begin
                    r_sel   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_sel   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_omsp_spm_key_loader.sv
// Directed bench for omsp_spm_key_loader; SM modelled as owning 0x8000-0x8FFF.
module tb_omsp_spm_key_loader;

    localparam int unsigned KIS = 3;
    localparam int unsigned KW  = 8;

    logic           mclk      = 1'b0;
    logic           puc_rst_n = 1'b1;
    logic           start     = 1'b0;
    logic [15:0]    sm_addr   = 16'h0;
    logic           abort     = 1'b0;
    logic           word_valid = 1'b0;
    logic [15:0]    word_data = 16'h0;
    logic           ks_en     = 1'b1;
    logic           word_ready;
    logic           key_selected;
    logic [15:0]    spm_key_select;
    logic           write_key;
    logic [15:0]    key_in;
    logic [KIS-1:0] key_idx;
    logic           busy;
    logic           done;
    logic           error;

    int n_checks  = 0;
    int n_err     = 0;
    int wr_count  = 0;
    int rdy_count = 0;
    int snap_wr;
    int snap_rdy;

    omsp_spm_key_loader #(.KEY_IDX_SIZE(KIS), .KEY_WORDS(KW)) dut (
        .mclk           (mclk),
        .puc_rst_n      (puc_rst_n),
        .start          (start),
        .sm_addr        (sm_addr),
        .abort          (abort),
        .word_valid     (word_valid),
        .word_data      (word_data),
        .word_ready     (word_ready),
        .key_selected   (key_selected),
        .spm_key_select (spm_key_select),
        .write_key      (write_key),
        .key_in         (key_in),
        .key_idx        (key_idx),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    // Protected module model: selected while the broadcast address is inside its public section.
    assign key_selected = ks_en && (spm_key_select >= 16'h8000) && (spm_key_select < 16'h9000);

    always #5 mclk = ~mclk;

    always @(negedge mclk) begin
        if (write_key === 1'b1) wr_count++;
        if (word_ready === 1'b1) rdy_count++;
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a load and step into CHECK.
    task automatic start_load(input logic [15:0] a);
        sm_addr = a;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("sel_latch", 32'(spm_key_select), 32'(a));
        chk("busy_check", 32'(busy), 32'd1);
        chk("ready_check", 32'(word_ready), 32'd0);
    endtask

    // Offer one word in LOAD; the write must be visible one cycle later.
    task automatic load_word(input int idx, input logic [15:0] d);
        word_valid = 1'b1;
        word_data  = d;
        tick();
        word_valid = 1'b0;
        chk("wr_strobe", 32'(write_key), 32'd1);
        chk("wr_idx", 32'(key_idx), 32'(idx));
        chk("wr_data", 32'(key_in), 32'(d));
    endtask

    initial begin
        // Reset state
        #2 puc_rst_n = 1'b0;
        tick();
        tick();
        chk("rst_sel", 32'(spm_key_select), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_write", 32'(write_key), 32'd0);
        chk("rst_ready", 32'(word_ready), 32'd0);
        chk("rst_done_err", 32'({done, error}), 32'd0);
        puc_rst_n = 1'b1;
        tick();

        // Full back-to-back load
        start_load(16'h8100);
        tick();
        chk("ready_load", 32'(word_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            load_word(i, 16'(16'h1111 * (i + 1)));
            if (i < 7) word_valid = 1'b1;
        end
        chk("sel_hold_last", 32'(spm_key_select), 32'h8100);
        chk("done_not_yet", 32'(done), 32'd0);
        chk("ready_after_last", 32'(word_ready), 32'd0);
        tick();
        chk("done_pulse", 32'(done), 32'd1);
        chk("sel_cleared", 32'(spm_key_select), 32'd0);
        chk("no_extra_write", 32'(write_key), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("full_load_writes", 32'(wr_count), 32'd8);
        chk("key_in_hold", 32'(key_in), 32'h8888);

        // Start outside any SM
        snap_wr  = wr_count;
        snap_rdy = rdy_count;
        start_load(16'h7000);
        chk("err_not_yet", 32'(error), 32'd0);
        tick();
        chk("err_pulse", 32'(error), 32'd1);
        tick();
        chk("err_one_cycle", 32'(error), 32'd0);
        chk("err_idle", 32'(busy), 32'd0);
        chk("err_no_writes", 32'(wr_count - snap_wr), 32'd0);
        chk("err_no_ready", 32'(rdy_count - snap_rdy), 32'd0);

        // Stalled source: valid 1,0,0,...
        snap_wr = wr_count;
        start_load(16'h8100);
        tick();
        for (int j = 0; j < 8; j++) begin
            load_word(j, 16'(16'hB000 + j));
            tick();
            chk("stall_gap1", 32'(write_key), 32'd0);
            if (j == 7) chk("stall_done", 32'(done), 32'd1);
            tick();
            chk("stall_gap2", 32'(write_key), 32'd0);
        end
        chk("stall_writes", 32'(wr_count - snap_wr), 32'd8);

        // Abort on the 4th handshake
        snap_wr = wr_count;
        start_load(16'h8100);
        tick();
        for (int j = 0; j < 3; j++) load_word(j, 16'(16'hC000 + j));
        word_valid = 1'b1;
        word_data  = 16'hC003;
        abort      = 1'b1;
        #1;
        chk("abort_ready", 32'(word_ready), 32'd0);
        tick();
        abort      = 1'b0;
        word_valid = 1'b0;
        chk("abort_no_write", 32'(write_key), 32'd0);
`ifdef SM_KEY_WIPE_EN
        chk("abort_wipe_noerr", 32'(error), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("wipe_strobe", 32'(write_key), 32'd1);
            chk("wipe_idx", 32'(key_idx), 32'(k));
            chk("wipe_data", 32'(key_in), 32'd0);
        end
        chk("abort_err", 32'(error), 32'd1);
        tick();
        chk("abort_writes", 32'(wr_count - snap_wr), 32'd11);
`else
        chk("abort_err", 32'(error), 32'd1);
        tick();
        chk("abort_writes", 32'(wr_count - snap_wr), 32'd3);
`endif
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_err_end", 32'(error), 32'd0);

        // key_selected drops after the 2nd write
        snap_wr = wr_count;
        start_load(16'h8100);
        tick();
        for (int j = 0; j < 2; j++) load_word(j, 16'(16'hD000 + j));
        word_valid = 1'b1;
        ks_en      = 1'b0;
        #1;
        chk("drop_ready", 32'(word_ready), 32'd0);
        tick();
        word_valid = 1'b0;
        chk("drop_no_write", 32'(write_key), 32'd0);
`ifdef SM_KEY_WIPE_EN
        tick();
`endif
        chk("drop_err", 32'(error), 32'd1);
        tick();
        ks_en = 1'b1;
        chk("drop_writes", 32'(wr_count - snap_wr), 32'd2);
        chk("drop_idle", 32'(busy), 32'd0);

        // Abort during DONE suppresses done
        start_load(16'h8100);
        tick();
        for (int j = 0; j < 8; j++) load_word(j, 16'(16'hE000 + j));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done_nodone", 32'(done), 32'd0);
`ifdef SM_KEY_WIPE_EN
        repeat (8) tick();
`endif
        chk("abort_done_err", 32'(error), 32'd1);
        tick();
        chk("abort_done_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-load at idx 5
        start_load(16'h8100);
        tick();
        for (int j = 0; j < 6; j++) load_word(j, 16'(16'hF000 + j));
        #2 puc_rst_n = 1'b0;
        #1;
        chk("arst_write", 32'(write_key), 32'd0);
        chk("arst_idx", 32'(key_idx), 32'd0);
        chk("arst_key_in", 32'(key_in), 32'd0);
        chk("arst_sel", 32'(spm_key_select), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        snap_wr = wr_count;
        tick();
        tick();
        chk("arst_no_strobes", 32'(wr_count - snap_wr), 32'd0);
        puc_rst_n = 1'b1;
        tick();
        chk("arst_resume_idle", 32'(busy), 32'd0);
        start_load(16'h8200);
        tick();
        for (int j = 0; j < 8; j++) begin
            load_word(j, 16'(16'h0101 * (j + 1)));
            if (j < 7) word_valid = 1'b1;
        end
        tick();
        chk("arst_reload_done", 32'(done), 32'd1);
        chk("arst_reload_writes", 32'(wr_count - snap_wr), 32'd8);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
